// File: rtl/mem_req_ctrl_pkg.sv
// mem_req_ctrl_pkg: state encoding and byte-lane constants shared by the memory request controller.
package mem_req_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    // Big-endian lanes, selected by address bit 0.
    localparam logic LANE_HI = 1'b0;
    localparam logic LANE_LO = 1'b1;

    function automatic logic [15:0] word_addr(input logic [15:0] a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_req_ctrl_byte_lane.sv
// mem_req_ctrl_byte_lane: extracts a zero-extended byte from a read word and merges a byte into a word.
module mem_req_ctrl_byte_lane
    import mem_req_ctrl_pkg::*;
(
    input  logic [15:0] rd_word,
    input  logic [15:0] mg_word,
    input  logic [7:0]  wbyte,
    input  logic        lane,
    output logic [15:0] ext,
    output logic [15:0] merged
);

    assign ext    = {8'h00, lane == LANE_LO ? rd_word[7:0] : rd_word[15:8]};
    assign merged = lane == LANE_LO ? {mg_word[15:8], wbyte} : {wbyte, mg_word[7:0]};

endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: byte/word load-store controller for an aligned-only 16-bit memory; byte stores use read-modify-write.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_enable,
    output logic        mem_wr,
    input  logic [15:0] mem_data_out,
    input  logic        mem_err
);

    state_t      state;
    logic        byte_q;
    logic        lane_q;
    logic        err_q;
    logic [15:0] wdata_q;
    logic [15:0] merge_q;
    logic [15:0] ext;
    logic [15:0] merged;

    mem_req_ctrl_byte_lane u_lane (
        .rd_word (mem_data_out),
        .mg_word (merge_q),
        .wbyte   (wdata_q[7:0]),
        .lane    (lane_q),
        .ext     (ext),
        .merged  (merged)
    );

    // Enable and write are gated by rst so a reset landing on RMW_WR never writes.
    assign req_ready   = !rst && state == IDLE;
    assign mem_enable  = !rst && state inside {RD, WR, RMW_RD, RMW_WR};
    assign mem_wr      = !rst && state inside {WR, RMW_WR};
    assign mem_data_in = state == WR ? wdata_q : state == RMW_WR ? merged : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 16'h0000;
            resp_err   <= 1'b0;
            mem_addr   <= 16'h0000;
            byte_q     <= 1'b0;
            lane_q     <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= 16'h0000;
            merge_q    <= 16'h0000;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    mem_addr   <= word_addr(req_addr);
                    byte_q     <= req_byte;
                    lane_q     <= req_addr[0];
                    wdata_q    <= req_wdata;
                    err_q      <= 1'b0;
                    resp_rdata <= 16'h0000;
                    if (!req_byte && req_addr[0]) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        state <= !req_wr ? RD : req_byte ? RMW_RD : WR;
                    end
                end
                RD: begin
                    resp_rdata <= mem_err ? 16'h0000 : byte_q ? ext : mem_data_out;
                    resp_err   <= err_q | mem_err;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                WR, RMW_WR: begin
                    resp_err   <= err_q | mem_err;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_RD: begin
                    merge_q <= mem_data_out;
                    err_q   <= err_q | mem_err;
                    state   <= RMW_WR;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: scoreboard bench with a behavioural memory and a word-array reference model.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic        req_byte = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_data_out;
    logic        mem_err;
    logic        inj_err = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int en_cnt = 0;

    logic [15:0] mem     [0:32767] = '{default: 16'h0};
    logic [15:0] ref_mem [0:32767] = '{default: 16'h0};

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t sb[$];

    mem_req_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_byte     (req_byte),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr),
        .mem_data_out (mem_data_out),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    // Single-cycle aligned memory: combinational read, write on the rising edge.
    assign mem_data_out = (mem_enable && !mem_wr) ? mem[mem_addr[15:1]] : 16'h0000;
    assign mem_err      = inj_err && mem_enable;

    always @(posedge clk) begin
        if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_data_in;
        cyc <= cyc + 1;
        if (mem_wr) wr_cnt <= wr_cnt + 1;
        if (mem_enable) en_cnt <= en_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_enable) chk("mem_addr_even", int'(mem_addr[0]), 0);
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_cycle", cyc, e.due);
                    chk("resp_rdata", int'(resp_rdata), int'(e.rdata));
                    chk("resp_err", int'(resp_err), int'(e.err));
                end
            end
        end
    end

    // Issue one request from a negedge; the expected response comes from the reference model.
    task automatic issue(input logic wr, input logic byt, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic inj, input logic push,
                         output int acc);
        int n;
        exp_t e;
        logic [15:0] w;
        logic [7:0]  b;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_byte  = byt;
        req_addr  = addr;
        req_wdata = wdata;
        inj_err   = inj;
        acc       = cyc;
        w = ref_mem[addr[15:1]];
        b = addr[0] ? w[7:0] : w[15:8];
        if (!byt && addr[0]) begin
            e.rdata = 16'h0000;
            e.err   = 1'b1;
            e.due   = acc + 1;
        end else if (!wr) begin
            e.rdata = inj ? 16'h0000 : byt ? {8'h00, b} : w;
            e.err   = inj;
            e.due   = acc + 2;
        end else begin
            e.rdata = 16'h0000;
            e.err   = inj;
            e.due   = acc + (byt ? 3 : 2);
            if (push) ref_mem[addr[15:1]] = !byt ? wdata :
                addr[0] ? {w[15:8], wdata[7:0]} : {wdata[7:0], w[7:0]};
        end
        if (push) sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int acc, acc2, base_wr, base_en;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_mem_enable", int'(mem_enable), 0);
        chk("rst_mem_wr", int'(mem_wr), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_rdata", int'(resp_rdata), 0);
        chk("rst_resp_err", int'(resp_err), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_data_in", int'(mem_data_in), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(req_ready), 1);

        issue(1, 0, 16'h0010, 16'hABCD, 0, 1, acc);
        drain();
        issue(0, 0, 16'h0010, 16'h0, 0, 1, acc);
        issue(0, 1, 16'h0011, 16'h0, 0, 1, acc);
        issue(0, 1, 16'h0010, 16'h0, 0, 1, acc);
        drain();

        base_wr = wr_cnt;
        issue(1, 1, 16'h0010, 16'h005A, 0, 1, acc);
        drain();
        chk("rmw_wr_pulses", wr_cnt - base_wr, 1);
        issue(0, 0, 16'h0010, 16'h0, 0, 1, acc);
        drain();

        base_en = en_cnt;
        issue(0, 0, 16'h0013, 16'h0, 0, 1, acc);
        drain();
        chk("misaligned_no_enable", en_cnt - base_en, 0);

        issue(1, 0, 16'h0020, 16'h1234, 0, 1, acc);
        chk("b2b_ready_c1", int'(req_ready), 0);
        @(negedge clk);
        chk("b2b_ready_c2", int'(req_ready), 0);
        issue(0, 0, 16'h0020, 16'h0, 0, 1, acc2);
        chk("b2b_accept_gap", acc2 - acc, 3);
        drain();

        base_wr = wr_cnt;
        issue(1, 1, 16'h0011, 16'h00EE, 0, 0, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", int'(req_ready), 0);
        rst = 1'b0;
        chk("rst_mid_no_write", wr_cnt - base_wr, 0);
        @(negedge clk);
        chk("rst_mid_ready_back", int'(req_ready), 1);
        issue(0, 0, 16'h0010, 16'h0, 0, 1, acc);
        drain();

        issue(1, 1, 16'hFFFF, 16'h0077, 0, 1, acc);
        issue(0, 0, 16'hFFFE, 16'h0, 0, 1, acc);
        issue(1, 0, 16'h0030, 16'hBEEF, 1, 1, acc);
        issue(0, 1, 16'h0030, 16'h0, 1, 1, acc);
        drain();

        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 15) == 0) ? 16'hFFF8 | 16'($urandom_range(0, 7))
                                              : 16'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                  16'($urandom), $urandom_range(0, 7) == 0, 1, acc);
        end
        drain();
        inj_err = 1'b0;
        for (int i = 0; i < 32; i++) begin
            issue(0, 0, 16'(i * 2), 16'h0, 0, 1, acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
